// File: rtl/am_demod_decim_if.sv
// rtl/am_demod_decim_if.sv - demodulator stream in, decimated sample/peak/status out
interface am_demod_decim_if;
  logic signed [47:0] in_data;
  logic               in_valid;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic        [15:0] peak_out;
  logic               peak_valid;
  logic               sat_flag;

  modport master (
    output in_data, in_valid,
    input  sample_out, sample_valid, peak_out, peak_valid, sat_flag
  );

  modport slave (
    input  in_data, in_valid,
    output sample_out, sample_valid, peak_out, peak_valid, sat_flag
  );
endinterface

// File: rtl/am_demod_decim.sv
// rtl/am_demod_decim.sv - boxcar decimator, scale/saturate, warm-up and windowed peak
// Optional leaky DC tracker enabled by defining AM_DC_BLOCK_EN.
module am_demod_decim #(
  parameter int DECIM    = 16,
  parameter int SHIFT    = 24,
  parameter int SKIP     = 2,
  parameter int PEAK_WIN = 64,
  parameter int DC_K     = 4
) (
  input logic             clk_in,
  input logic             rst,
  am_demod_decim_if.slave bus
);
  localparam int LOG2  = $clog2(DECIM);
  localparam int ACC_W = 48 + LOG2;
  localparam int YW    = ACC_W + 1;
  localparam int WW    = $clog2(SKIP + 2);
  localparam int PW    = $clog2(PEAK_WIN + 1);
  localparam logic signed [YW-1:0] MAX_V = YW'(32767);
  localparam logic signed [YW-1:0] MIN_V = -YW'(32768);

  typedef enum logic {WARM, RUN} state_t;
  state_t state, next_state;
  logic   run;

  logic signed [ACC_W-1:0] acc, acc_next, sum_reg, avg;
  logic        [LOG2-1:0]  cnt;
  logic                    pend;
  logic        [WW-1:0]    warm_cnt;
  logic        [PW-1:0]    win_cnt;
  logic        [15:0]      run_max, mag, peak_cand;
  logic signed [YW-1:0]    y, v;
  logic signed [15:0]      sat_val;
  logic                    sat_hi, sat_lo;

  assign acc_next = acc + {{LOG2{bus.in_data[47]}}, bus.in_data};

  always_ff @(posedge clk_in) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      sum_reg <= '0;
      pend    <= 1'b0;
    end else begin
      pend <= 1'b0;
      if (bus.in_valid) begin
        if (cnt == LOG2'(DECIM - 1)) begin
          sum_reg <= acc_next;
          acc     <= '0;
          cnt     <= '0;
          pend    <= 1'b1;
        end else begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign avg = sum_reg >>> LOG2;

`ifdef AM_DC_BLOCK_EN
  logic signed [47:0] dc_est;
  assign y = {avg[ACC_W-1], avg} - {{(YW-48){dc_est[47]}}, dc_est};

  // Tracker leaks toward avg during warm-up too, so the first RUN sample is already partly cancelled.
  always_ff @(posedge clk_in) begin
    if (rst) dc_est <= '0;
    else if (pend) dc_est <= 48'({{(YW-48){dc_est[47]}}, dc_est} + (y >>> DC_K));
  end
`else
  assign y = {avg[ACC_W-1], avg};
`endif

  assign v      = y >>> SHIFT;
  assign sat_hi = v > MAX_V;
  assign sat_lo = v < MIN_V;

  always_comb begin
    sat_val = v[15:0];
    if (sat_hi)      sat_val = 16'sh7FFF;
    else if (sat_lo) sat_val = -16'sh8000;
  end

  // |-32768| folds to 32767 so the peak stays within the positive 16-bit range.
  always_comb begin
    mag = sat_val;
    if (sat_val == -16'sh8000) mag = 16'h7FFF;
    else if (sat_val[15])      mag = ~sat_val + 16'd1;
  end

  assign peak_cand = (mag > run_max) ? mag : run_max;

  always_ff @(posedge clk_in) begin
    if (rst) state <= WARM;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    run        = 1'b0;
    case (state)
      WARM: begin
        if (SKIP == 0) next_state = RUN;
        else if (pend && warm_cnt == WW'(SKIP - 1)) next_state = RUN;
      end
      RUN: run = 1'b1;
      default: next_state = WARM;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      bus.sample_out   <= '0;
      bus.sample_valid <= 1'b0;
      bus.peak_out     <= '0;
      bus.peak_valid   <= 1'b0;
      bus.sat_flag     <= 1'b0;
      warm_cnt         <= '0;
      win_cnt          <= '0;
      run_max          <= '0;
    end else begin
      bus.sample_valid <= 1'b0;
      bus.peak_valid   <= 1'b0;
      if (pend) begin
        if (sat_hi || sat_lo) bus.sat_flag <= 1'b1;
        if (run) begin
          bus.sample_out   <= sat_val;
          bus.sample_valid <= 1'b1;
          if (win_cnt == PW'(PEAK_WIN - 1)) begin
            bus.peak_out   <= peak_cand;
            bus.peak_valid <= 1'b1;
            run_max        <= '0;
            win_cnt        <= '0;
          end else begin
            run_max <= peak_cand;
            win_cnt <= win_cnt + 1'b1;
          end
        end else begin
          warm_cnt <= warm_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_am_demod_decim.sv
// tb/tb_am_demod_decim.sv - directed self-checking bench for am_demod_decim
module tb_am_demod_decim;
  localparam logic [47:0] C_CONST = 48'h0012_3400_0000;
  localparam logic [47:0] C_MAX   = 48'h7FFF_FFFF_FFFF;
  localparam logic [47:0] C_MIN   = 48'h8000_0000_0000;
  localparam logic [47:0] C_ONE   = 48'h0000_0100_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stray_peak = 0;

  int          q_cyc[$];
  logic [15:0] q_val[$];
  logic        q_pk[$];
  logic [15:0] q_pko[$];

  am_demod_decim_if bus ();

  am_demod_decim #(.DECIM(16), .SHIFT(24), .SKIP(2), .PEAK_WIN(4), .DC_K(4)) dut (
    .clk_in(clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // cyc equals k during the k-th cycle after reset release
  always @(posedge clk) begin
    if (rst) cyc <= 1;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (bus.sample_valid) begin
      q_cyc.push_back(cyc);
      q_val.push_back(bus.sample_out);
      q_pk.push_back(bus.peak_valid);
      q_pko.push_back(bus.peak_out);
    end else if (bus.peak_valid) begin
      stray_peak++;
    end
  end

  function automatic logic [47:0] enc(input int v);
    longint t;
    t = longint'(v) <<< 24;
    return t[47:0];
  endfunction

  task automatic clear_log;
    q_cyc.delete();
    q_val.delete();
    q_pk.delete();
    q_pko.delete();
    stray_peak = 0;
  endtask

  task automatic do_reset;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_log();
  endtask

  task automatic feed(input logic [47:0] d, input int n);
    repeat (n) begin
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = C_MAX;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.sample_out !== 16'h0000) begin errors++; $display("FAIL reset_sample_out got %h want 0000", bus.sample_out); end
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sample_valid got %b want 0", bus.sample_valid); end
    checks++; if (bus.peak_out !== 16'h0000) begin errors++; $display("FAIL reset_peak_out got %h want 0000", bus.peak_out); end
    checks++; if (bus.peak_valid !== 1'b0) begin errors++; $display("FAIL reset_peak_valid got %b want 0", bus.peak_valid); end
    checks++; if (bus.sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag got %b want 0", bus.sat_flag); end
  endtask

  task automatic test_constant;
    do_reset();
    feed(C_CONST, 80);
    idle(4);
    checks++; if (q_val.size() !== 3) begin errors++; $display("FAIL const_count got %0d want 3", q_val.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < q_val.size()) begin
        checks++; if (q_cyc[i] !== 50 + 16 * i) begin errors++; $display("FAIL const_cycle[%0d] got %0d want %0d", i, q_cyc[i], 50 + 16 * i); end
        checks++; if (q_val[i] !== 16'h1234) begin errors++; $display("FAIL const_value[%0d] got %h want 1234", i, q_val[i]); end
      end
    end
    checks++; if (bus.sat_flag !== 1'b0) begin errors++; $display("FAIL const_sat got %b want 0", bus.sat_flag); end
  endtask

  task automatic test_saturation;
    logic [15:0] exp_v [4];
    exp_v = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
    do_reset();
    feed(C_MAX, 64);
    feed(C_MIN, 32);
    idle(4);
    checks++; if (q_val.size() !== 4) begin errors++; $display("FAIL sat_count got %0d want 4", q_val.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < q_val.size()) begin
        checks++; if (q_val[i] !== exp_v[i]) begin errors++; $display("FAIL sat_value[%0d] got %h want %h", i, q_val[i], exp_v[i]); end
      end
    end
    if (q_val.size() == 4) begin
      checks++; if (q_pk[3] !== 1'b1 || q_pko[3] !== 16'h7FFF) begin errors++; $display("FAIL sat_peak got valid=%b peak=%h want valid=1 peak=7fff", q_pk[3], q_pko[3]); end
    end
    feed(C_ONE, 32);
    idle(4);
    checks++; if (bus.sat_flag !== 1'b1) begin errors++; $display("FAIL sat_sticky got %b want 1", bus.sat_flag); end
  endtask

  task automatic test_gapped;
    do_reset();
    repeat (64) begin
      feed(C_ONE, 1);
      idle(1);
    end
    idle(4);
    checks++; if (q_val.size() !== 2) begin errors++; $display("FAIL gap_count got %0d want 2", q_val.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < q_val.size()) begin
        checks++; if (q_cyc[i] !== 97 + 32 * i) begin errors++; $display("FAIL gap_cycle[%0d] got %0d want %0d", i, q_cyc[i], 97 + 32 * i); end
        checks++; if (q_val[i] !== 16'h0001) begin errors++; $display("FAIL gap_value[%0d] got %h want 0001", i, q_val[i]); end
      end
    end
  endtask

  task automatic test_peak_window;
    logic [15:0] exp_v [8];
    exp_v = '{16'd5, 16'hFED4, 16'd7, 16'd2, 16'd1, 16'd1, 16'd1, 16'd1};
    do_reset();
    feed(enc(0), 32);
    feed(enc(5), 16);
    feed(enc(-300), 16);
    feed(enc(7), 16);
    feed(enc(2), 16);
    feed(enc(1), 64);
    idle(4);
    checks++; if (q_val.size() !== 8) begin errors++; $display("FAIL peak_count got %0d want 8", q_val.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < q_val.size()) begin
        checks++; if (q_val[i] !== exp_v[i]) begin errors++; $display("FAIL peak_sample[%0d] got %h want %h", i, q_val[i], exp_v[i]); end
        checks++; if (q_pk[i] !== (i == 3 || i == 7)) begin errors++; $display("FAIL peak_strobe[%0d] got %b want %b", i, q_pk[i], (i == 3 || i == 7)); end
      end
    end
    if (q_val.size() == 8) begin
      checks++; if (q_pko[3] !== 16'd300) begin errors++; $display("FAIL peak_win1 got %0d want 300", q_pko[3]); end
      checks++; if (q_pko[7] !== 16'd1) begin errors++; $display("FAIL peak_win2 got %0d want 1", q_pko[7]); end
    end
    checks++; if (stray_peak !== 0) begin errors++; $display("FAIL peak_stray got %0d want 0", stray_peak); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    feed(C_MAX, 16);
    feed(C_CONST, 9);
    checks++; if (bus.sat_flag !== 1'b1) begin errors++; $display("FAIL mid_presat got %b want 1", bus.sat_flag); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_log();
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL mid_no_strobe got %b want 0", bus.sample_valid); end
    checks++; if (bus.sat_flag !== 1'b0) begin errors++; $display("FAIL mid_sat got %b want 0", bus.sat_flag); end
    feed(C_CONST, 64);
    idle(4);
    checks++; if (q_val.size() !== 2) begin errors++; $display("FAIL mid_count got %0d want 2", q_val.size()); end
    if (q_val.size() > 0) begin
      checks++; if (q_cyc[0] !== 50) begin errors++; $display("FAIL mid_first_cycle got %0d want 50", q_cyc[0]); end
      checks++; if (q_val[0] !== 16'h1234) begin errors++; $display("FAIL mid_first_value got %h want 1234", q_val[0]); end
    end
  endtask

`ifdef AM_DC_BLOCK_EN
  task automatic test_dc_block;
    int hit;
    do_reset();
    feed(C_CONST, 16 * 202);
    idle(4);
    checks++; if (q_val.size() !== 200) begin errors++; $display("FAIL dc_count got %0d want 200", q_val.size()); end
    if (q_val.size() > 0) begin
      checks++; if (!($signed(q_val[0]) < 16'sh1234 && $signed(q_val[0]) > 0)) begin errors++; $display("FAIL dc_first got %h want in (0,1234)", q_val[0]); end
    end
    hit = 0;
    for (int i = 0; i < q_val.size(); i++) begin
      if (i > 0) begin
        checks++; if ($signed(q_val[i]) > $signed(q_val[i-1])) begin errors++; $display("FAIL dc_monotonic[%0d] got %h after %h", i, q_val[i], q_val[i-1]); end
      end
      if ($signed(q_val[i]) == 0 || $signed(q_val[i]) == -1) hit = 1;
    end
    checks++; if (hit !== 1) begin errors++; $display("FAIL dc_settle got %0d want 1", hit); end
  endtask
`endif

  initial begin
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    test_reset();
    test_constant();
    test_saturation();
    test_gapped();
    test_peak_window();
    test_reset_mid();
`ifdef AM_DC_BLOCK_EN
    test_dc_block();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/am_demod_decim.md
# am_demod_decim

Post-demodulation output stage that sits directly downstream of the AM demodulator. It accepts the demodulator's 48-bit signed product/filter stream at full clock rate and decimates it by boxcar averaging. It scales and saturates the result to a 16-bit signed baseband sample with a one-cycle valid strobe, and reports a windowed peak amplitude for level monitoring.

## Interface
- `DECIM`, 16: decimation ratio; power of two, 2..256.
- `SHIFT`, 24: arithmetic right shift applied to the averaged value before 16-bit saturation.
- `SKIP`, 2: decimated outputs suppressed after reset (warm-up).
- `PEAK_WIN`, 64: output samples per peak-measurement window.
- `DC_K`, 4: DC-tracker leak shift (only with `AM_DC_BLOCK_EN`).
- `clk_in`: input, 1 bit. The single clock; all logic is rising-edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `in_data`: input, 48 bits, signed. Demodulator output.
- `in_valid`: input, 1 bit. `in_data` qualifier; tie high for a continuous stream.
- `sample_out`: output, 16 bits, signed. Decimated baseband sample.
- `sample_valid`: output, 1 bit. One-cycle strobe; `sample_out` is new.
- `peak_out`: output, 16 bits, unsigned. Maximum |sample_out| over the last window.
- `peak_valid`: output, 1 bit. One-cycle strobe; `peak_out` is new.
- `sat_flag`: output, 1 bit. Sticky; set when any output saturated.

## Operation
- Reset clears everything to zero:
  - Outputs: `sample_out`, `sample_valid`, `peak_out`, `peak_valid`, `sat_flag`.
  - Internal state: accumulator, input counter, warm-up counter, window counter, running peak, DC estimate.
  - FSM enters `WARM`.
- Accumulation:
  - Each accepted input (`in_valid`=1) is added to a signed accumulator of width 48+log2(DECIM). The input counter advances 0..DECIM-1.
  - On the accepted input with count = DECIM-1, the total including that input is latched into `sum_reg`. The accumulator reloads to 0 and the count wraps to 0; no input is lost.
  - `in_valid`=0 holds the accumulator and counter unchanged.
- Output computation, stage 2, one cycle after the latch:
  - avg = `sum_reg` >>> log2(DECIM).
  - v = avg >>> SHIFT, both shifts arithmetic.
  - Saturation: v > 32767 gives 32767; v < -32768 gives -32768. Either case sets `sat_flag`.
  - `sat_flag` clears only on `rst`.
- FSM:
  - In `WARM`, each stage-2 result is computed but `sample_valid` stays 0, and the peak logic is not updated.
  - After SKIP results, the FSM moves to `RUN`. With SKIP=0 the FSM leaves `WARM` immediately after reset.
  - `RUN` is held until `rst`.
  - Saturation during `WARM` still sets `sat_flag`.
- Peak tracking, in `RUN` only:
  - |sample_out| is folded into a running max; |-32768| = 32767.
  - On the PEAK_WIN-th valid sample, the max including that sample goes to `peak_out` and `peak_valid` pulses.
  - The running max then restarts from 0.

## Timing
- The last input of a frame is presented in cycle N and latched into `sum_reg` at the edge ending cycle N.
- `sample_out` and `sample_valid` update at the following edge, so `sample_valid` is high during cycle N+2.
- Latency from last input to strobe is 2 clocks.
- With continuous `in_valid`, strobes are exactly DECIM cycles apart. `sample_valid` is never high on two consecutive cycles, since DECIM ≥ 2.
- `peak_valid` is high in the same cycle as the `sample_valid` that completes the window.
- `sample_out` holds its last value between strobes. `peak_out` holds between window ends.
- `rst` asserted mid-frame discards the partial sum and any pending stage-2 result. No strobe is issued in the cycle after a reset edge.

## Configuration
- `AM_DC_BLOCK_EN` defined: a leaky DC tracker is inserted between avg and the SHIFT stage.
  - y = avg − dc_est, with dc_est 48-bit signed and reset to 0.
  - At each stage-2 result: dc_est <= dc_est + ((avg − dc_est) >>> DC_K).
  - The tracker updates during `WARM` as well.
  - y feeds SHIFT and saturation.
- `AM_DC_BLOCK_EN` undefined: y = avg. There is no dc_est register and `DC_K` is unused.

## Test plan
Defaults apply (DECIM=16, SHIFT=24, SKIP=2) unless stated.
- Constant input, no DC block: `in_data`=48'h0012_3400_0000, `in_valid`=1 from the first cycle after `rst` falls.
  - First `sample_valid` at cycle 3·16+2 = 50 after reset release.
  - `sample_out`=16'h1234 every 16 cycles; `sat_flag`=0.
- Saturation:
  - `in_data`=48'h7FFF_FFFF_FFFF gives `sample_out`=16'h7FFF and `sat_flag`=1.
  - Then `in_data`=48'h8000_0000_0000 gives 16'h8000. `sat_flag` stays 1 until `rst`.
  - `peak_out`=16'h7FFF at the window end.
- Gapped input: `in_valid` toggling 1,0,1,0 with a constant 48'h0000_0100_0000.
  - `sample_out`=1 on every strobe.
  - Strobes spaced 32 cycles apart.
- Peak window, PEAK_WIN=4: per-frame input producing outputs 5, −300, 7, 2.
  - Single `peak_valid` with `peak_out`=300, coincident with the strobe for 2.
  - Next window starts from 0.
- Reset mid-frame: assert `rst` for 1 cycle after 9 inputs of a frame.
  - No strobe in the cycle after the reset edge.
  - Warm-up restarts; the next strobe is 50 cycles after release.
  - `sat_flag`=0.
- `AM_DC_BLOCK_EN` with constant 48'h0012_3400_0000:
  - First valid `sample_out` is below 16'h1234 and above 0.
  - Strictly non-increasing thereafter.
  - Reaches 0 or −1 within 200 strobes.
